// File: rtl/control_sequencer.sv
// Three-cycle fetch/decode/execute sequencer owning the program counter.
// Optional build macro CALL_STACK_EN adds a 4-entry return stack for CALL/RET.
//
// state   | meaning
// FETCH   | PC presented to program ROM
// DECODE  | ROM data settles, IR loads on exit
// EXECUTE | instruction fields valid, PC updated on exit
// HALT    | stopped until rst
module control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       zeroFlag,
    input  logic [1:0] instructionType,
    input  logic [2:0] instructionCode,
    input  logic [7:0] literalOrAddress,
    output logic [2:0] state,
    output logic [7:0] romAddress,
    output logic       halted,
    output logic       stackFault
);

    typedef enum logic [2:0] {
        FETCH   = 3'b000,
        DECODE  = 3'b001,
        EXECUTE = 3'b010,
        HALT    = 3'b011
    } state_t;

    state_t     state_q;
    logic [7:0] pc;
    logic [7:0] pc_inc;
    logic [7:0] pc_next;
    logic       go_halt;

    assign state      = state_q;
    assign romAddress = pc;
    assign pc_inc     = pc + 8'd1;

`ifdef CALL_STACK_EN
    logic [7:0] stack [0:3];
    logic [2:0] sp;
    logic [2:0] sp_m1;
    logic       push;
    logic       pop;
    logic       fault;
    logic       stack_fault_q;

    assign sp_m1      = sp - 3'd1;
    assign stackFault = stack_fault_q;
`else
    assign stackFault = 1'b0;
`endif

    always_comb begin
        pc_next = pc_inc;
        go_halt = 1'b0;
`ifdef CALL_STACK_EN
        push  = 1'b0;
        pop   = 1'b0;
        fault = 1'b0;
`endif
        if (instructionType == 2'b11) begin
            case (instructionCode)
                3'b000: pc_next = literalOrAddress;
                3'b001: if (zeroFlag)  pc_next = literalOrAddress;
                3'b010: if (!zeroFlag) pc_next = literalOrAddress;
`ifdef CALL_STACK_EN
                3'b011: begin
                    if (sp == 3'd4) fault = 1'b1;
                    else begin
                        push    = 1'b1;
                        pc_next = literalOrAddress;
                    end
                end
                3'b100: begin
                    if (sp == 3'd0) fault = 1'b1;
                    else begin
                        pop     = 1'b1;
                        pc_next = stack[sp_m1[1:0]];
                    end
                end
`endif
                3'b111: go_halt = 1'b1;
                default: pc_next = pc_inc;
            endcase
        end
`ifdef CALL_STACK_EN
        if (fault) go_halt = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc      <= 8'h00;
            halted  <= 1'b0;
`ifdef CALL_STACK_EN
            sp            <= 3'd0;
            stack_fault_q <= 1'b0;
            for (int i = 0; i < 4; i++) stack[i] <= 8'h00;
`endif
        end else if (!stall) begin
            case (state_q)
                FETCH:  state_q <= DECODE;
                DECODE: state_q <= EXECUTE;
                EXECUTE: begin
                    if (go_halt) begin
                        state_q <= HALT;
                        halted  <= 1'b1;
`ifdef CALL_STACK_EN
                        stack_fault_q <= fault;
`endif
                    end else begin
                        state_q <= FETCH;
                        pc      <= pc_next;
`ifdef CALL_STACK_EN
                        if (push) begin
                            stack[sp[1:0]] <= pc_inc;
                            sp             <= sp + 3'd1;
                        end else if (pop) begin
                            sp <= sp_m1;
                        end
`endif
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-003 SHALL have port stall, input, 1 bit; while 1, the state and every register are held.
REQ-004 SHALL have port zeroFlag, input, 1 bit, ALU zero result; sampled only in EXECUTE.
REQ-005 SHALL have port instructionType, input, 2 bits, from the instruction register.
REQ-006 SHALL have port instructionCode, input, 3 bits, from the instruction register.
REQ-007 SHALL have port literalOrAddress, input, 8 bits, from the instruction register; used as the branch target.
REQ-008 SHALL have port state, output, 3 bits, the current machine state, driven to the instruction register and datapath.
REQ-009 SHALL have port romAddress, output, 8 bits, the program counter, driven to the program ROM.
REQ-010 SHALL have port halted, output, 1 bit; high while in the HALT state.
REQ-011 SHALL have port stackFault, output, 1 bit; sticky call-stack error.

Function
REQ-012 SHALL encode the states as FETCH=3'b000, DECODE=3'b001, EXECUTE=3'b010 and HALT=3'b011; no other code is ever driven.
REQ-013 SHALL advance FETCH->DECODE->EXECUTE->FETCH, one state per unstalled clock, so each instruction takes exactly 3 cycles.
REQ-014 SHALL drive romAddress directly from the PC register; the PC SHALL be stable across FETCH and DECODE, so the IR captures romData at the DECODE->EXECUTE edge.
REQ-015 SHALL update the PC only on the EXECUTE->FETCH edge; the instruction fields are valid throughout EXECUTE.
REQ-016 SHALL decode branch-class instructions only when instructionType==2'b11; every other type SHALL give PC<=PC+1.
REQ-017 SHALL decode the branch-class codes as: 000 JMP (PC<=literal); 001 JZ (PC<=literal if zeroFlag==1, else PC+1); 010 JNZ (PC<=literal if zeroFlag==0, else PC+1); 011 CALL; 100 RET; 101 and 110 NOP (PC+1); 111 HLT.
REQ-018 SHALL perform the PC increment mod 256, so 8'hFF wraps to 8'h00 with no flag.
REQ-019 SHALL, on HLT in EXECUTE, enter HALT, set halted=1 and leave the PC unchanged.
REQ-020 SHALL hold HALT until rst; stall has no effect while in HALT.
REQ-021 SHALL, when stall=1 at a clock edge, hold state, PC, stack pointer and stack contents with no other side effect; if stall=1 during EXECUTE, zeroFlag SHALL be sampled on the first unstalled edge.

Reset
REQ-022 SHALL, when rst is asserted, immediately set state=FETCH, PC=8'h00, halted=0, stackFault=0 and stack pointer=0, independent of clk.
REQ-023 SHALL give rst priority over stall, including mid-instruction and in HALT; any instruction in flight is abandoned.
REQ-024 SHALL, on the first clock edge after rst deasserts, move from FETCH to DECODE with romAddress=8'h00.

Configuration
REQ-025 SHALL, with macro CALL_STACK_EN defined, include a 4-entry 8-bit return stack: CALL pushes PC+1 (wrapped) and sets PC<=literal; RET sets PC<=popped value.
REQ-026 SHALL, with CALL_STACK_EN defined, make CALL on a full stack or RET on an empty stack enter HALT with stackFault=1 and halted=1, leaving stack and PC unchanged.
REQ-027 SHALL, without CALL_STACK_EN, omit the stack, execute CALL and RET as NOP (PC+1), and tie stackFault to 0; the port list is identical in both builds.

Verification
REQ-028 Reset then free-run on type 00 instructions -> state cycles 000,001,010; romAddress 00,01,02 changes every 3 clocks.
REQ-029 JZ (11,001,literal 8'h40) with zeroFlag=1 -> romAddress=8'h40 in the next FETCH; repeat with zeroFlag=0 -> PC+1.
REQ-030 PC=8'hFF with a type 01 instruction -> romAddress=8'h00 next FETCH; stall held 5 cycles in DECODE -> state and PC frozen, then resume.
REQ-031 With CALL_STACK_EN: CALL 8'h20 at PC 8'h05, then RET -> PC 20 then 06; 5 nested CALLs -> fifth gives halted=1, stackFault=1, PC unchanged.
REQ-032 HLT -> halted=1, state=011 held 10 cycles regardless of stall; rst pulse mid-EXECUTE -> state=000 and romAddress=00 before the next clk edge.
